// File: rtl/conv_line_ctrl.sv
// ============================================================================
// Module   : conv_line_ctrl
// Purpose  : Raster sequencing controller for a 3x3 convolution datapath.
//            Drives line FIFO enables and flags window validity and frame end.
//            Optional FIFO misuse checker enabled by CONV_LINE_CTRL_ERR_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_line_ctrl #(
    parameter int IMG_W  = 360,
    parameter int IMG_H  = 360,
    parameter int COL_W  = 9,
    parameter int ROW_W  = 9,
    parameter int STEP_W = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    output logic              ready_in,
    input  logic              full_fifo1,
    input  logic              empty_fifo1,
    input  logic              full_fifo2,
    input  logic              empty_fifo2,
    output logic              fifo1_wr_en,
    output logic              fifo1_rd_en,
    output logic              fifo2_wr_en,
    output logic              fifo2_rd_en,
    output logic              fifo_clr,
    output logic              window_valid,
    output logic [COL_W-1:0]  col,
    output logic [ROW_W-1:0]  row,
    output logic [STEP_W-1:0] step,
    output logic              frame_done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [ROW_W-1:0]  ROW_ONE  = ROW_W'(1);
    localparam logic [ROW_W-1:0]  ROW_TWO  = ROW_W'(2);
    localparam logic [COL_W-1:0]  COL_TWO  = COL_W'(2);

    state_t              state_q, state_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic                clr_q;
    logic                win_q, win_d;

    logic                accept;
    logic                col_wrap;
    logic                last_px;

    assign ready_in = (state_q != DONE) && !clr_q;
    assign accept   = valid_in && ready_in;
    assign col_wrap = (col_q == COL_LAST);
    assign last_px  = col_wrap && (row_q == ROW_LAST);

    // Line 0 only fills FIFO1; from line 1 FIFO1 shifts into FIFO2; from line 2 FIFO2 drains.
    assign fifo1_wr_en = accept;
    assign fifo1_rd_en = accept && (row_q >= ROW_ONE);
    assign fifo2_wr_en = accept && (row_q >= ROW_ONE);
    assign fifo2_rd_en = accept && (row_q >= ROW_TWO);

    assign fifo_clr     = clr_q || (state_q == DONE);
    assign frame_done   = (state_q == DONE);
    assign window_valid = win_q;
    assign col          = col_q;
    assign row          = row_q;
    assign step         = step_q;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        step_d  = step_q;
        win_d   = accept && (row_q >= ROW_TWO) && (col_q >= COL_TWO);

        if (accept) begin
            step_d = step_q + STEP_W'(1);
            if (col_wrap) begin
                col_d = '0;
                row_d = row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
            if (last_px) begin
                col_d  = '0;
                row_d  = '0;
                step_d = '0;
            end
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (accept && (row_q == ROW_TWO) && (col_q == '0)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (accept && last_px) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            step_q  <= '0;
            clr_q   <= 1'b1;
            win_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            step_q  <= step_d;
            clr_q   <= 1'b0;
            win_q   <= win_d;
        end
    end

`ifdef CONV_LINE_CTRL_ERR_EN
    logic err_q;
    logic misuse;

    assign misuse = (fifo1_wr_en && full_fifo1)  || (fifo1_rd_en && empty_fifo1) ||
                    (fifo2_wr_en && full_fifo2)  || (fifo2_rd_en && empty_fifo2);

    // Sticky until reset; frame boundaries and FIFO clears leave it untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (misuse) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_flags;

    assign unused_flags = full_fifo1 ^ empty_fifo1 ^ full_fifo2 ^ empty_fifo2;
    assign err          = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_conv_line_ctrl.sv
// Self-checking bench for conv_line_ctrl on a 5x4 frame.
`default_nettype none

module tb_conv_line_ctrl;

    localparam int W      = 5;
    localparam int H      = 4;
    localparam int COL_W  = 3;
    localparam int ROW_W  = 2;
    localparam int STEP_W = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              valid_in;
    logic [3:0]        fl;
    logic              ready_in;
    logic              fifo1_wr_en, fifo1_rd_en, fifo2_wr_en, fifo2_rd_en;
    logic              fifo_clr, window_valid, frame_done, err;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [STEP_W-1:0] step;

    conv_line_ctrl #(
        .IMG_W(W), .IMG_H(H), .COL_W(COL_W), .ROW_W(ROW_W), .STEP_W(STEP_W)
    ) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
        .full_fifo1(fl[3]), .empty_fifo1(fl[2]), .full_fifo2(fl[1]), .empty_fifo2(fl[0]),
        .fifo1_wr_en(fifo1_wr_en), .fifo1_rd_en(fifo1_rd_en),
        .fifo2_wr_en(fifo2_wr_en), .fifo2_rd_en(fifo2_rd_en),
        .fifo_clr(fifo_clr), .window_valid(window_valid),
        .col(col), .row(row), .step(step),
        .frame_done(frame_done), .err(err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int win_seen = 0;

    // Reference model: frame position as a plain pixel count.
    int m_n;
    bit m_done, m_clr, m_win, m_err;

`ifdef CONV_LINE_CTRL_ERR_EN
    localparam bit ERR_BUILD = 1'b1;
`else
    localparam bit ERR_BUILD = 1'b0;
`endif

    typedef struct {
        int px;
        bit rd1;
        bit rd2;
        bit win;
        bit done;
    } vec_t;

    vec_t tbl[10];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_n    = 0;
        m_done = 1'b0;
        m_clr  = 1'b1;
        m_win  = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic check_all();
        int r;
        int c;
        bit rdy;
        bit acc;
        r   = m_n / W;
        c   = m_n % W;
        rdy = !m_done && !m_clr;
        acc = valid_in && rdy;
        chk1("ready_in", ready_in, rdy);
        chk1("fifo1_wr_en", fifo1_wr_en, acc);
        chk1("fifo1_rd_en", fifo1_rd_en, acc && r >= 1);
        chk1("fifo2_wr_en", fifo2_wr_en, acc && r >= 1);
        chk1("fifo2_rd_en", fifo2_rd_en, acc && r >= 2);
        chk1("fifo_clr", fifo_clr, m_clr || m_done);
        chk1("window_valid", window_valid, m_win);
        chk1("frame_done", frame_done, m_done);
        chk1("err", err, m_err);
        chkn("col", 32'(col), c);
        chkn("row", 32'(row), r);
        chkn("step", 32'(step), m_n);
    endtask

    // Called at a negedge; drives inputs, checks, advances one clock, returns at next negedge.
    task automatic step_cycle(input bit v, input logic [3:0] flags, input bit do_check);
        int  r;
        int  c;
        bit  acc;
        bit  misuse;
        valid_in = v;
        fl       = flags;
        #1;
        if (do_check) check_all();
        if (window_valid === 1'b1) win_seen++;
        r      = m_n / W;
        c      = m_n % W;
        acc    = v && !m_done && !m_clr;
        misuse = (acc && flags[3]) || (acc && r >= 1 && flags[2]) ||
                 (acc && r >= 1 && flags[1]) || (acc && r >= 2 && flags[0]);
        @(posedge clk);
        m_win = acc && r >= 2 && c >= 2;
        if (ERR_BUILD && misuse) m_err = 1'b1;
        m_clr  = 1'b0;
        m_done = 1'b0;
        if (acc) begin
            m_n++;
            if (m_n == W * H) begin
                m_n    = 0;
                m_done = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    // Asserts reset mid-cycle (asynchronous), checks, releases at the next negedge.
    task automatic do_reset();
        #2;
        reset    = 1'b0;
        valid_in = 1'b0;
        fl       = 4'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic feed(input int n);
        for (int k = 0; k < n; k++) step_cycle(1'b1, 4'b0, 1'b1);
    endtask

    initial begin
        reset    = 1'b0;
        valid_in = 1'b0;
        fl       = 4'b0;
        model_reset();

        tbl[0] = '{4,  1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{5,  1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{9,  1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{10, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{11, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{12, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{14, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[7] = '{15, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[8] = '{17, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[9] = '{19, 1'b1, 1'b1, 1'b1, 1'b1};

        @(negedge clk);
        do_reset();
        // Reset release: clear still up for one cycle, then idle with ready.
        chk1("clr_after_release", fifo_clr, 1'b1);
        step_cycle(1'b0, 4'b0, 1'b1);
        chk1("clr_dropped", fifo_clr, 1'b0);
        chk1("ready_idle", ready_in, 1'b1);
        step_cycle(1'b0, 4'b0, 1'b1);

        // Table: enables at a given pixel index and window/done one edge later.
        foreach (tbl[i]) begin
            do_reset();
            step_cycle(1'b0, 4'b0, 1'b1);
            feed(tbl[i].px);
            valid_in = 1'b1;
            fl       = 4'b0;
            #1;
            chk1($sformatf("tbl%0d_rd1", tbl[i].px), fifo1_rd_en, tbl[i].rd1);
            chk1($sformatf("tbl%0d_rd2", tbl[i].px), fifo2_rd_en, tbl[i].rd2);
            step_cycle(1'b1, 4'b0, 1'b1);
            chk1($sformatf("tbl%0d_win", tbl[i].px), window_valid, tbl[i].win);
            chk1($sformatf("tbl%0d_done", tbl[i].px), frame_done, tbl[i].done);
        end

        // Full continuous frame.
        do_reset();
        step_cycle(1'b0, 4'b0, 1'b1);
        win_seen = 0;
        feed(W * H);
        chk1("frame_done_after_last", frame_done, 1'b1);
        chkn("step_wrapped", 32'(step), 0);
        step_cycle(1'b0, 4'b0, 1'b1);
        chk1("frame_done_one_cycle", frame_done, 1'b0);
        chkn("windows_continuous", win_seen, (W - 2) * (H - 2));

        // Same frame with valid_in low every other cycle.
        win_seen = 0;
        for (int i = 0; i < 2 * W * H; i++) step_cycle(i % 2 == 0, 4'b0, 1'b1);
        step_cycle(1'b0, 4'b0, 1'b1);
        chkn("windows_gapped", win_seen, (W - 2) * (H - 2));

        // valid_in held across the frame boundary.
        feed(W * H);
        valid_in = 1'b1;
        #1;
        chk1("boundary_ready", ready_in, 1'b0);
        chk1("boundary_no_accept", fifo1_wr_en, 1'b0);
        step_cycle(1'b1, 4'b0, 1'b1);
        valid_in = 1'b1;
        #1;
        chk1("boundary_accept", fifo1_wr_en, 1'b1);
        chkn("boundary_col", 32'(col), 0);
        chkn("boundary_row", 32'(row), 0);
        step_cycle(1'b1, 4'b0, 1'b1);
        chkn("boundary_col_next", 32'(col), 1);

        // Reset mid-frame after pixel 8, then a clean frame.
        do_reset();
        step_cycle(1'b0, 4'b0, 1'b1);
        feed(8);
        do_reset();
        chkn("midrst_step", 32'(step), 0);
        chk1("midrst_win", window_valid, 1'b0);
        chk1("midrst_clr", fifo_clr, 1'b1);
        step_cycle(1'b0, 4'b0, 1'b1);
        win_seen = 0;
        feed(W * H);
        step_cycle(1'b0, 4'b0, 1'b1);
        chkn("midrst_windows", win_seen, (W - 2) * (H - 2));

        // FIFO2 reported empty while it is read at pixel 11.
        do_reset();
        step_cycle(1'b0, 4'b0, 1'b1);
        feed(11);
        step_cycle(1'b1, 4'b0001, 1'b1);
        chk1("err_set", err, ERR_BUILD);
        feed(W * H - 12);
        chk1("err_at_done", err, ERR_BUILD);
        chk1("err_done_flag", frame_done, 1'b1);
        step_cycle(1'b0, 4'b0, 1'b1);
        chk1("err_sticky", err, ERR_BUILD);

        // Randomized traffic, flags and occasional resets against the model.
        do_reset();
        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(0, 249) == 0) begin
                do_reset();
            end else begin
                step_cycle($urandom_range(0, 3) != 0,
                           ($urandom_range(0, 19) == 0) ? 4'($urandom_range(0, 15)) : 4'b0,
                           1'b1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
